alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 88 ++++++++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: widths, opcodes, FSM states.
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;

  // Opcodes shared with the ALU decoder. Codes 1000-1111 fall back to ADD.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for opcodes served by the 32-step iterative datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result bus of the ALU execution unit. The master issues operations
// and consumes results; the slave is the execution unit itself.
interface alu_exec_unit_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            kill;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    output in_valid, alu_control, src_a, src_b, kill, out_ready,
    input  in_ready, result, zero, out_valid, busy
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, kill, out_ready,
    output in_ready, result, zero, out_valid, busy
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// 32-step iterative datapath: unsigned shift-add multiply (low word of the
// product) and unsigned restoring divide (quotient). done is high during the
// cycle whose closing edge performs the final step; result is valid after it.
module alu_muldiv_iter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic            abort,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITER_COUNT);

  logic             running_reg;
  logic [CNT_W-1:0] count_reg;
  logic             div_reg;
  // MUL: a_reg = shifted multiplicand, b_reg = shifted multiplier, acc_reg = product.
  // DIV: a_reg = dividend shifting out / quotient shifting in, b_reg = divisor,
  //      acc_reg = partial remainder.
  logic [XLEN-1:0]  a_reg, b_reg, acc_reg;
  logic [XLEN-1:0]  a_next, b_next, acc_next;
  logic [XLEN:0]    rem_shift, rem_diff;

  // One multiply or divide step computed from the current partial registers.
  always_comb begin
    a_next    = a_reg;
    b_next    = b_reg;
    acc_next  = acc_reg;
    rem_shift = {acc_reg, a_reg[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    if (div_reg) begin
      // A zero divisor never borrows, so the quotient saturates to all ones.
      if (!rem_diff[XLEN]) begin
        acc_next = rem_diff[XLEN-1:0];
        a_next   = {a_reg[XLEN-2:0], 1'b1};
      end else begin
        acc_next = rem_shift[XLEN-1:0];
        a_next   = {a_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      if (b_reg[0]) begin
        acc_next = acc_reg + a_reg;
      end
      a_next = a_reg << 1;
      b_next = b_reg >> 1;
    end
  end

  assign done   = running_reg && (count_reg == CNT_W'(ITER_COUNT - 1));
  assign result = div_reg ? a_reg : acc_reg;

  // Load operands on start, then step once per cycle for ITER_COUNT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_reg <= 1'b0;
      count_reg   <= '0;
      div_reg     <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
    end else if (abort) begin
      running_reg <= 1'b0;
      count_reg   <= '0;
    end else if (start) begin
      running_reg <= 1'b1;
      count_reg   <= '0;
      div_reg     <= is_div;
      a_reg       <= op_a;
      b_reg       <= op_b;
      acc_reg     <= '0;
    end else if (running_reg) begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      count_reg <= count_reg + 1'b1;
      if (done) begin
        running_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus iterative
// MUL/DIV, with a valid/ready request side, a held result side and a kill flush.
// The first DONE cycle captures the result; out_valid rises on that edge.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  state_t          state_reg;
  logic [3:0]      op_reg;
  logic [XLEN-1:0] a_reg, b_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;
  logic            out_valid_reg;

  logic            accept;
  logic            iter_start;
  logic            iter_done;
  logic [XLEN-1:0] iter_result;
  logic [XLEN-1:0] alu_value;

  assign accept     = bus.in_valid && (state_reg == ST_IDLE) && !bus.kill;
  assign iter_start = accept && is_iter_op(bus.alu_control);

  alu_muldiv_iter u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .is_div (bus.alu_control == OP_DIV),
    .abort  (bus.kill),
    .op_a   (bus.src_a),
    .op_b   (bus.src_b),
    .done   (iter_done),
    .result (iter_result)
  );

  // Result selection from the registered operands; MUL/DIV take the iterator output.
  always_comb begin
    alu_value = a_reg + b_reg;
    case (op_reg)
      OP_ADD:         alu_value = a_reg + b_reg;
      OP_SUB:         alu_value = a_reg - b_reg;
      OP_MUL, OP_DIV: alu_value = iter_result;
      OP_AND:         alu_value = a_reg & b_reg;
      OP_OR:          alu_value = a_reg | b_reg;
      OP_XOR:         alu_value = a_reg ^ b_reg;
      OP_NOT:         alu_value = ~a_reg;
      default:        alu_value = a_reg + b_reg;
    endcase
  end

  // Control FSM with registered result, zero flag and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (bus.kill) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg    <= bus.alu_control;
            a_reg     <= bus.src_a;
            b_reg     <= bus.src_b;
            state_reg <= is_iter_op(bus.alu_control) ? ST_BUSY : ST_DONE;
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_reg) begin
            result_reg    <= alu_value;
            zero_reg      <= (alu_value == '0);
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.busy      = (state_reg == ST_BUSY);
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random
// operations, compared each cycle against a transaction-level model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  alu_exec_unit_if bus ();

  alu_exec_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int fail_prints = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      if (fail_prints < 40) begin
        $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
      end
      fail_prints++;
    end
  endtask

  // Reference arithmetic straight from the opcode table.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      4'd3: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return ~a;
      default: return a + b;
    endcase
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3);
  endfunction

  // Transaction-level model: an accepted op yields its value a fixed number of
  // cycles later (1 or 33), long ops report busy for their first 32 cycles.
  logic        m_idle, m_valid, m_zero;
  int          m_left, m_busy_left;
  logic [31:0] m_result, m_pending;

  // Advance the model on each rising edge using the inputs driven earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_left <= 0; m_busy_left <= 0;
      m_result <= 32'd0; m_zero <= 1'b1; m_pending <= 32'd0;
    end else if (bus.kill) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_left <= 0; m_busy_left <= 0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0;
        m_idle  <= 1'b1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
      if (m_left == 1) begin
        m_valid  <= 1'b1;
        m_result <= m_pending;
        m_zero   <= (m_pending == 32'd0);
      end
    end else if (m_idle && bus.in_valid) begin
      m_idle    <= 1'b0;
      m_pending <= ref_op(bus.alu_control, bus.src_a, bus.src_b);
      m_left      <= is_long(bus.alu_control) ? 33 : 1;
      m_busy_left <= is_long(bus.alu_control) ? 32 : 0;
    end
  end

  // Compare every DUT output against the model on every falling edge.
  always @(negedge clk) begin
    check("cyc_in_ready", {31'd0, bus.in_ready}, {31'd0, m_idle});
    check("cyc_busy", {31'd0, bus.busy}, {31'd0, (m_busy_left > 0)});
    check("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    check("cyc_result", bus.result, m_result);
    check("cyc_zero", {31'd0, bus.zero}, {31'd0, m_zero});
  end

  // Issue one op, wait for its result, hold out_ready low for 'hold' cycles, then take it.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat;
    int busy_cyc;
    bus.in_valid = 1'b1;
    bus.alu_control = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_control = 4'($urandom);
    bus.src_a = $urandom();
    bus.src_b = $urandom();
    lat = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cyc++;
    end
    $display("op %s ctl=%h a=%08h b=%08h -> result=%08h zero=%0d latency=%0d", name, op, a, b, bus.result, bus.zero, lat);
    check({name, "_latency"}, 32'(lat), is_long(op) ? 32'd33 : 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cyc), is_long(op) ? 32'd32 : 32'd0);
    check({name, "_result"}, bus.result, exp);
    check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_result"}, bus.result, exp);
      check({name, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({name, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_idle_after"}, {31'd0, bus.in_ready}, 32'd1);
    check({name, "_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    int          saw_valid;

    bus.in_valid = 1'b0;
    bus.alu_control = 4'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Literal pins on the reference arithmetic.
    check("model_mul", ref_op(4'd2, 32'd1234, 32'd5678), 32'd7006652);
    check("model_div0", ref_op(4'd3, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_sub", ref_op(4'd1, 32'd5, 32'd7), 32'hFFFF_FFFE);

    // Directed corner cases with hand-computed results.
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("not", 4'd7, 32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0, 0);
    run_op("mul_ovf", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 0);
    run_op("mul", 4'd2, 32'd1234, 32'd5678, 32'd7006652, 10);
    run_op("div", 4'd3, 32'd100, 32'd7, 32'd14, 0);
    run_op("div0", 4'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("and", 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0);
    run_op("xor", 4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0);
    run_op("ext_add", 4'hC, 32'd3, 32'd4, 32'd7, 0);

    // Kill in the 15th BUSY cycle of a multiply.
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd2;
    bus.src_a = 32'd77;
    bus.src_b = 32'd99;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    $display("kill mid-mul -> in_ready=%0d busy=%0d out_valid=%0d", bus.in_ready, bus.busy, bus.out_valid);
    check("kill_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) saw_valid++;
    end
    check("kill_no_valid", 32'(saw_valid), 32'd0);

    // Asynchronous reset in the middle of a divide.
    bus.in_valid = 1'b1;
    bus.alu_control = 4'd3;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("reset mid-div -> out_valid=%0d busy=%0d result=%08h zero=%0d", bus.out_valid, bus.busy, bus.result, bus.zero);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_result", bus.result, 32'd0);
    check("mrst_zero", {31'd0, bus.zero}, 32'd1);
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 0);

    // Randomized operations against the reference arithmetic.
    for (int n = 0; n < 40; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 20));
        default: r_b = $urandom();
      endcase
      run_op("rand", r_op, r_a, r_b, ref_op(r_op, r_a, r_b), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
